// File: rtl/vga_sync_gen.sv
// vga_sync_gen: pixel timing source for the VGA pipeline.
// A clock divider produces the pixel enable. Nested column and line counters
// advance on that enable. Every output comes straight from a flop, and
// video_on, hsync and vsync are computed from the counter values being
// loaded, so each one describes the same pixel as pixel_x/pixel_y.
module vga_sync_gen #(
    parameter int CLK_DIV   = 2,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] Y_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] div;
    logic             tick;
    logic [9:0]       x_next;
    logic [9:0]       y_next;
    logic             video_next;
    logic             hsync_next;
    logic             vsync_next;
    logic             frame_next;

    // Pixel enable fires on the last clock of each divider period.
    // With CLK_DIV=1 the divider stays at zero, so the enable fires every clock.
    always_comb begin
        tick = (div == DIV_LAST);
    end

    // Divider: counts 0..CLK_DIV-1 and wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + DIV_ONE;
        end
    end

    // Next counter position, and the timing flags that describe that position.
    always_comb begin
        x_next = (pixel_x == X_LAST) ? 10'd0 : pixel_x + 10'd1;
        y_next = pixel_y;
        if (pixel_x == X_LAST) begin
            y_next = (pixel_y == Y_LAST) ? 10'd0 : pixel_y + 10'd1;
        end
        video_next = (x_next < X_VIS) && (y_next < Y_VIS);
        hsync_next = !((x_next >= HS_START) && (x_next < HS_END));
        vsync_next = !((y_next >= VS_START) && (y_next < VS_END));
        frame_next = (x_next == 10'd0) && (y_next == 10'd0);
    end

    // Counters and registered outputs. Everything except the pulses holds between ticks.
    // Reset parks the counters on the last pixel, so the first tick opens a complete frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_tick      <= 1'b0;
            pixel_x     <= X_LAST;
            pixel_y     <= Y_LAST;
            video_on    <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            p_tick      <= tick;
            frame_start <= tick && frame_next;
            if (tick) begin
                pixel_x  <= x_next;
                pixel_y  <= y_next;
                video_on <= video_next;
                hsync    <= hsync_next;
                vsync    <= vsync_next;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen with three instances:
//  - the default 640x480 timing at CLK_DIV=2;
//  - the same timing at CLK_DIV=1;
//  - a shrunken frame at CLK_DIV=3, small enough that whole frames fit in a short run.
// Expected output vectors come from a closed-form model indexed by the number of
// clocks since reset release. They are queued at each rising edge and compared
// at the following falling edge.
module tb_vga_sync_gen;

    logic clk;
    logic reset_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic       d_pt, d_von, d_hs, d_vs, d_fs;
    logic [9:0] d_x, d_y;
    logic       o_pt, o_von, o_hs, o_vs, o_fs;
    logic [9:0] o_x, o_y;
    logic       s_pt, s_von, s_hs, s_vs, s_fs;
    logic [9:0] s_x, s_y;

    vga_sync_gen #(.CLK_DIV(2)) dut_d (
        .clk(clk), .reset_n(reset_n), .p_tick(d_pt), .pixel_x(d_x), .pixel_y(d_y),
        .video_on(d_von), .hsync(d_hs), .vsync(d_vs), .frame_start(d_fs)
    );

    vga_sync_gen #(.CLK_DIV(1)) dut_o (
        .clk(clk), .reset_n(reset_n), .p_tick(o_pt), .pixel_x(o_x), .pixel_y(o_y),
        .video_on(o_von), .hsync(o_hs), .vsync(o_vs), .frame_start(o_fs)
    );

    vga_sync_gen #(
        .CLK_DIV(3), .H_DISPLAY(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
        .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) dut_s (
        .clk(clk), .reset_n(reset_n), .p_tick(s_pt), .pixel_x(s_x), .pixel_y(s_y),
        .video_on(s_von), .hsync(s_hs), .vsync(s_vs), .frame_start(s_fs)
    );

    logic [24:0] obs_d, obs_o, obs_s;
    assign obs_d = {d_pt, d_fs, d_von, d_hs, d_vs, d_y, d_x};
    assign obs_o = {o_pt, o_fs, o_von, o_hs, o_vs, o_y, o_x};
    assign obs_s = {s_pt, s_fs, s_von, s_hs, s_vs, s_y, s_x};

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Vector layout: {p_tick, frame_start, video_on, hsync, vsync, y[9:0], x[9:0]}.
    function automatic logic [24:0] model(input int k, input int d,
                                          input int hd, input int hf, input int hs, input int hb,
                                          input int vd, input int vf, input int vs, input int vb);
        int   ht;
        int   vt;
        int   n;
        int   p;
        int   x;
        int   y;
        logic pt, fs, von, hsn, vsn;
        ht = hd + hf + hs + hb;
        vt = vd + vf + vs + vb;
        n  = k / d;
        if (n == 0) begin
            x = ht - 1;
            y = vt - 1;
        end else begin
            p = (n - 1) % (ht * vt);
            x = p % ht;
            y = p / ht;
        end
        pt  = (k > 0) && (k % d == 0);
        fs  = pt && (x == 0) && (y == 0);
        von = (x < hd) && (y < vd);
        hsn = !((x >= hd + hf) && (x < hd + hf + hs));
        vsn = !((y >= vd + vf) && (y < vd + vf + vs));
        return {pt, fs, von, hsn, vsn, 10'(y), 10'(x)};
    endfunction

    typedef struct {
        int          id;
        logic [24:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  k;

    task automatic push_all();
        sb_t e;
        e.id = 0; e.exp = model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33); sb_q.push_back(e);
        e.id = 1; e.exp = model(k, 1, 640, 16, 96, 48, 480, 10, 2, 33); sb_q.push_back(e);
        e.id = 2; e.exp = model(k, 3, 16, 4, 6, 4, 12, 2, 2, 3);         sb_q.push_back(e);
    endtask

    // Scoreboard drain: compare every queued expectation at the falling edge.
    always @(negedge clk) begin
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.id)
                0:       check_val("vec_def",   {7'd0, obs_d}, {7'd0, e.exp});
                1:       check_val("vec_div1",  {7'd0, obs_o}, {7'd0, e.exp});
                default: check_val("vec_small", {7'd0, obs_s}, {7'd0, e.exp});
            endcase
        end
    end

    // Per-line statistics for the default instance: ticks per line, hsync-low ticks, video ticks.
    int d_cnt = 0, d_hlow = 0, d_vid = 0, d_lines = 0, d_seen = 0;
    int d_line = 0, d_hlow_l = 0, d_vid_l = 0;
    always @(negedge clk) begin
        if (reset_n && d_pt) begin
            if (d_x == 10'd0) begin
                if (d_seen != 0) begin
                    d_line = d_cnt; d_hlow_l = d_hlow; d_vid_l = d_vid; d_lines++;
                end
                d_seen = 1; d_cnt = 0; d_hlow = 0; d_vid = 0;
            end
            d_cnt++;
            if (!d_hs) d_hlow++;
            if (d_von) d_vid++;
        end
    end

    // Clocks per line and hsync-low clocks for the CLK_DIV=1 instance.
    int o_clk = 0, o_mark = 0, o_seen = 0, o_line_clks = 0, o_hlow = 0, o_hlow_l = 0;
    always @(negedge clk) begin
        if (reset_n) begin
            o_clk++;
            if (o_pt && o_x == 10'd0) begin
                if (o_seen != 0) begin
                    o_line_clks = o_clk - o_mark; o_hlow_l = o_hlow;
                end
                o_mark = o_clk; o_seen = 1; o_hlow = 0;
            end
            if (!o_hs) o_hlow++;
        end
    end

    // Per-frame statistics for the small instance: frame period, vsync-low ticks, video ticks.
    int s_cnt = 0, s_vlow = 0, s_vid = 0, s_seen = 0, s_frames = 0;
    int s_period = 0, s_vlow_f = 0, s_vid_f = 0, s_fs_clks = 0;
    always @(negedge clk) begin
        if (reset_n) begin
            if (s_fs) s_fs_clks++;
            if (s_pt) begin
                if (s_fs) begin
                    if (s_seen != 0) begin
                        s_period = s_cnt; s_vlow_f = s_vlow; s_vid_f = s_vid; s_frames++;
                    end
                    s_seen = 1; s_cnt = 0; s_vlow = 0; s_vid = 0;
                end
                s_cnt++;
                if (!s_vs) s_vlow++;
                if (s_von) s_vid++;
            end
        end
    end

    localparam logic [24:0] RST_DEF   = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd524, 10'd799};
    localparam logic [24:0] RST_SMALL = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd18, 10'd29};

    initial begin
        reset_n = 1'b0;
        k       = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_def",   {7'd0, obs_d}, {7'd0, RST_DEF});
        check_val("rst_div1",  {7'd0, obs_o}, {7'd0, RST_DEF});
        check_val("rst_small", {7'd0, obs_s}, {7'd0, RST_SMALL});

        reset_n = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            @(posedge clk);
            k++;
            push_all();
        end
        @(negedge clk);
        #1;
        check_val("sb_drained",       32'(sb_q.size()), 32'd0);
        check_val("def_lines_seen",   32'(d_lines >= 2), 32'd1);
        check_val("def_line_ticks",   32'(d_line), 32'd800);
        check_val("def_hsync_ticks",  32'(d_hlow_l), 32'd96);
        check_val("def_video_ticks",  32'(d_vid_l), 32'd640);
        check_val("div1_line_clks",   32'(o_line_clks), 32'd800);
        check_val("div1_hsync_clks",  32'(o_hlow_l), 32'd96);
        check_val("small_frames",     32'(s_frames >= 2), 32'd1);
        check_val("small_period",     32'(s_period), 32'd570);
        check_val("small_vsync_tk",   32'(s_vlow_f), 32'd60);
        check_val("small_video_tk",   32'(s_vid_f), 32'd192);
        // Each small frame_start pulse lasts one clock; 6000 clks = 2000 ticks hit frame starts at ticks 1, 571, 1141, 1711.
        check_val("small_fs_clks",    32'(s_fs_clks), 32'd4);

        // Mid-frame reset, asserted between clock edges, must take effect immediately.
        @(posedge clk);
        #2;
        sb_q.delete();
        reset_n = 1'b0;
        #1;
        check_val("arst_def",   {7'd0, obs_d}, {7'd0, RST_DEF});
        check_val("arst_div1",  {7'd0, obs_o}, {7'd0, RST_DEF});
        check_val("arst_small", {7'd0, obs_s}, {7'd0, RST_SMALL});
        k = 0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            k++;
            push_all();
        end
        @(negedge clk);
        #1;
        check_val("sb_drained2", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
